// File: rtl/spi_sram_master.sv
// rtl/spi_sram_master.sv - byte-wide memory requests to SPI SRAM READ/WRITE frames
// Keeps cs_n low after a frame so address-sequential same-direction bytes stream without a new command.
module spi_sram_master #(
  parameter int ADDR_BITS = 24,
  parameter int DIV       = 1,
  parameter bit SEQ_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_done,
  output logic [7:0]           rsp_rdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);
  localparam int FRAME = 16 + ADDR_BITS;
  localparam int BW    = $clog2(FRAME + 1);
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] FULL_BITS = BW'(FRAME);
  localparam logic [BW-1:0] BYTE_BITS = BW'(8);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [FRAME-1:0]     sr_q, sr_d;
  logic [7:0]           rx_q, rx_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 lead_q, lead_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] last_addr_q, last_addr_d;
  logic                 last_wr_q, last_wr_d;
  logic                 last_vld_q, last_vld_d;
  logic                 pend_q, pend_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic [7:0]           rdata_q, rdata_d;

  logic accept;
  logic seq_hit;

  function automatic logic [FRAME-1:0] full_frame(input logic wr, input logic [ADDR_BITS-1:0] addr,
                                                  input logic [7:0] wdata);
    return {(wr ? 8'h02 : 8'h03), addr, (wr ? wdata : 8'h00)};
  endfunction

  assign accept  = req_valid && ready_q;
  assign seq_hit = SEQ_EN && last_vld_q && (req_wr == last_wr_q) &&
                   (req_addr == last_addr_q + ADDR_BITS'(1));

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    rx_d        = rx_q;
    bits_d      = bits_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    lead_d      = lead_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    last_wr_d   = last_wr_q;
    last_vld_d  = last_vld_q;
    pend_d      = pend_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          sr_d    = full_frame(req_wr, req_addr, req_wdata);
          bits_d  = FULL_BITS;
          cs_n_d  = 1'b0;
          mosi_d  = sr_d[FRAME-1];
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        lead_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (lead_q) begin
          // Streamed bytes get the same one-cycle lead-in a SETUP gives a full frame.
          lead_d = 1'b0;
        end else if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            rx_d    = {rx_q[6:0], miso};
            sr_d    = {sr_q[FRAME-2:0], 1'b0};
            mosi_d  = sr_d[FRAME-1];
            bits_d  = bits_q - BW'(1);
            if (bits_q == BW'(1)) begin
              done_d      = 1'b1;
              last_addr_d = addr_q;
              last_wr_d   = wr_q;
              last_vld_d  = 1'b1;
              if (!wr_q) rdata_d = rx_d;
              cs_n_d  = !SEQ_EN;
              state_d = SEQ_EN ? HOLD : GAP;
            end
          end
        end
      end
      HOLD: begin
        ready_d = 1'b1;
        if (accept) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          ready_d = 1'b0;
          if (seq_hit) begin
            sr_d    = {(req_wr ? req_wdata : 8'h00), {(FRAME-8){1'b0}}};
            bits_d  = BYTE_BITS;
            cnt_d   = '0;
            phase_d = 1'b0;
            lead_d  = 1'b1;
            mosi_d  = sr_d[FRAME-1];
            state_d = SHIFT;
          end else begin
            sr_d    = full_frame(req_wr, req_addr, req_wdata);
            bits_d  = FULL_BITS;
            pend_d  = 1'b1;
            cs_n_d  = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          cs_n_d  = 1'b0;
          mosi_d  = sr_q[FRAME-1];
          state_d = SETUP;
        end else begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      rx_q        <= '0;
      bits_q      <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      lead_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      last_addr_q <= '0;
      last_wr_q   <= 1'b0;
      last_vld_q  <= 1'b0;
      pend_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      rx_q        <= rx_d;
      bits_q      <= bits_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      lead_q      <= lead_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      last_wr_q   <= last_wr_d;
      last_vld_q  <= last_vld_d;
      pend_q      <= pend_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
endmodule
